// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic edge feeder.
// Imported by systolic_feeder and skew_lane.
package systolic_pkg;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int NE = N * N;
  localparam int TW = 3;

  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_e;

endpackage

// File: rtl/skew_lane.sv
// One skewed stream lane: picks element (t - idx) of a row/column.
// Ports: idx_i lane index, t_i feed counter, e*_i elements, elem_o out.
module skew_lane
  import systolic_pkg::*;
(
  input  logic [1:0]    idx_i,
  input  logic [TW-1:0] t_i,
  input  logic [DW-1:0] e0_i,
  input  logic [DW-1:0] e1_i,
  input  logic [DW-1:0] e2_i,
  output logic [DW-1:0] elem_o
);

  logic [TW-1:0] idx_w;
  logic [TW-1:0] k;

  assign idx_w = {1'b0, idx_i};
  assign k     = t_i - idx_w;

  // Slots before the lane's delay or past its 3 elements are padding.
  always_comb begin
    elem_o = '0;
    if (t_i >= idx_w) begin
      unique case (k)
        3'd0:    elem_o = e0_i;
        3'd1:    elem_o = e1_i;
        3'd2:    elem_o = e2_i;
        default: elem_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Stores A/B operands and drives the skewed west/north streams.
// Ports: load handshake, start, busy/out_valid/done, 3 west + 3 north.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int FLUSH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          load_sel,
  input  logic [3:0]    load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] inp_west0,
  output logic [DW-1:0] inp_west3,
  output logic [DW-1:0] inp_west6,
  output logic [DW-1:0] inp_north0,
  output logic [DW-1:0] inp_north1,
  output logic [DW-1:0] inp_north2,
  output logic          done
);

  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [FW-1:0] F_LAST =
    FW'((FLUSH > 0) ? FLUSH - 1 : 0);

  state_e        state_q;
  logic [TW-1:0] t_q;
  logic [FW-1:0] f_q;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;

  logic [DW-1:0] a_q  [NE];
  logic [DW-1:0] b_q  [NE];
  logic [DW-1:0] ws_q [N];
  logic [DW-1:0] ns_q [N];
  logic [DW-1:0] west [N];
  logic [DW-1:0] north[N];

  logic          wr_en;

  // busy_q also covers the done cycle, so a start or load
  // arriving alongside done is refused like any busy cycle.
  assign load_ready = ~busy_q;
  assign wr_en      = load_valid & ~busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NE; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else if (wr_en) begin
      for (int e = 0; e < NE; e++) begin
        if (load_addr == 4'(e)) begin
          if (load_sel) b_q[e] <= load_data;
          else          a_q[e] <= load_data;
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane u_west (
      .idx_i  (2'(i)),
      .t_i    (t_q),
      .e0_i   (a_q[i*N+0]),
      .e1_i   (a_q[i*N+1]),
      .e2_i   (a_q[i*N+2]),
      .elem_o (west[i])
    );
    skew_lane u_north (
      .idx_i  (2'(i)),
      .t_i    (t_q),
      .e0_i   (b_q[0*N+i]),
      .e1_i   (b_q[1*N+i]),
      .e2_i   (b_q[2*N+i]),
      .elem_o (north[i])
    );
  end

  // Streams are captured during each FEED cycle, so they appear
  // one cycle after the state; done is delayed the same way.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      f_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ws_q[k] <= '0;
        ns_q[k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ws_q[k] <= '0;
        ns_q[k] <= '0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start && !busy_q) begin
            state_q <= S_FEED;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_FEED: begin
          valid_q <= 1'b1;
          for (int k = 0; k < N; k++) begin
            ws_q[k] <= west[k];
            ns_q[k] <= north[k];
          end
          if (t_q == T_LAST) begin
            f_q <= '0;
            if (FLUSH == 0) state_q <= S_DONE;
            else            state_q <= S_FLUSH;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (f_q == F_LAST) state_q <= S_DONE;
          else               f_q <= f_q + 1'b1;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = valid_q;
  assign inp_west0  = ws_q[0];
  assign inp_west3  = ws_q[1];
  assign inp_west6  = ws_q[2];
  assign inp_north0 = ns_q[0];
  assign inp_north1 = ns_q[1];
  assign inp_north2 = ns_q[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + random bench for systolic_feeder (FLUSH=4 and FLUSH=0).
// Streams are checked against a matrix model using the skew rule.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_sel = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;

  logic        load_ready, busy, out_valid, done;
  logic [31:0] inp_west0, inp_west3, inp_west6;
  logic [31:0] inp_north0, inp_north1, inp_north2;

  logic        load_ready_z, busy_z, out_valid_z, done_z;
  logic [31:0] w0_z, w3_z, w6_z, n0_z, n1_z, n2_z;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ma [9];
  logic [31:0] mb [9];

  always #5 clk = ~clk;

  systolic_feeder #(.FLUSH(4)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_sel(load_sel), .load_addr(load_addr),
    .load_data(load_data), .start(start),
    .busy(busy), .out_valid(out_valid),
    .inp_west0(inp_west0), .inp_west3(inp_west3),
    .inp_west6(inp_west6), .inp_north0(inp_north0),
    .inp_north1(inp_north1), .inp_north2(inp_north2),
    .done(done)
  );

  systolic_feeder #(.FLUSH(0)) dut_z (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready_z),
    .load_sel(load_sel), .load_addr(load_addr),
    .load_data(load_data), .start(start),
    .busy(busy_z), .out_valid(out_valid_z),
    .inp_west0(w0_z), .inp_west3(w3_z),
    .inp_west6(w6_z), .inp_north0(n0_z),
    .inp_north1(n1_z), .inp_north2(n2_z),
    .done(done_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expw(input int i, input int t);
    int c = t - i;
    if (c >= 0 && c < 3) return ma[i*3+c];
    return 32'h0;
  endfunction

  function automatic logic [31:0] expn(input int j, input int t);
    int r = t - j;
    if (r >= 0 && r < 3) return mb[r*3+j];
    return 32'h0;
  endfunction

  task automatic chk_streams(input string tag, input int t);
    logic [31:0] o [6];
    o = '{inp_west0, inp_west3, inp_west6,
          inp_north0, inp_north1, inp_north2};
    for (int l = 0; l < 6; l++)
      chk($sformatf("%s:lane%0d", tag, l), o[l],
          (l < 3) ? expw(l, t) : expn(l - 3, t));
  endtask

  task automatic clear_model();
    for (int e = 0; e < 9; e++) begin
      ma[e] = '0;
      mb[e] = '0;
    end
  endtask

  task automatic load(input bit sel, input int addr,
                      input logic [31:0] data);
    chk("load_ready", load_ready, 1);
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = 4'(addr);
    load_data  = data;
    tick();
    load_valid = 1'b0;
    if (addr < 9) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  task automatic run(input string tag, input bit pre,
                     input bit glitch, input bit rst_mid);
    if (pre) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_addr  = 4'd0;
      load_data  = 32'hDEAD;
      ma[0]      = 32'hDEAD;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    chk({tag, ":busy_k"}, busy, 1);
    chk({tag, ":valid_k"}, out_valid, 0);
    chk({tag, ":ready_k"}, load_ready, 0);
    for (int s = 0; s < 5; s++) begin
      if (glitch && s == 2) start = 1'b1;
      if (glitch && s == 3) begin
        load_valid = 1'b1;
        load_sel   = 1'($urandom);
        load_addr  = 4'($urandom_range(0, 8));
        load_data  = $urandom;
      end
      if (rst_mid && s == 2) rst = 1'b1;
      tick();
      start = 1'b0;
      load_valid = 1'b0;
      if (rst_mid && s == 2) begin
        rst = 1'b0;
        chk({tag, ":rst_valid"}, out_valid, 0);
        chk({tag, ":rst_busy"}, busy, 0);
        chk({tag, ":rst_done"}, done, 0);
        chk({tag, ":rst_ready"}, load_ready, 1);
        chk({tag, ":rst_w0"}, inp_west0, 0);
        chk({tag, ":rst_w3"}, inp_west3, 0);
        chk({tag, ":rst_n0"}, inp_north0, 0);
        chk({tag, ":rst_n1"}, inp_north1, 0);
        clear_model();
        return;
      end
      chk($sformatf("%s:valid_t%0d", tag, s), out_valid, 1);
      chk($sformatf("%s:done_t%0d", tag, s), done, 0);
      chk($sformatf("%s:busy_t%0d", tag, s), busy, 1);
      chk_streams($sformatf("%s:t%0d", tag, s), s);
    end
    for (int f = 0; f < 4; f++) begin
      tick();
      chk($sformatf("%s:fvalid%0d", tag, f), out_valid, 0);
      chk($sformatf("%s:fdone%0d", tag, f), done, 0);
      chk_streams($sformatf("%s:f%0d", tag, f), 99);
      if (f == 0) chk({tag, ":z_done"}, done_z, 1);
      if (f == 1) begin
        chk({tag, ":z_done_end"}, done_z, 0);
        chk({tag, ":z_busy_end"}, busy_z, 0);
      end
    end
    tick();
    chk({tag, ":done"}, done, 1);
    chk({tag, ":done_busy"}, busy, 1);
    chk({tag, ":done_ready"}, load_ready, 0);
    chk({tag, ":done_w0"}, inp_west0, 0);
    tick();
    chk({tag, ":post_done"}, done, 0);
    chk({tag, ":post_busy"}, busy, 0);
    chk({tag, ":post_ready"}, load_ready, 1);
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_w0", inp_west0, 0);
    chk("rst_n2", inp_north2, 0);
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end

    for (int e = 0; e < 9; e++) begin
      load(1'b0, e, 32'(e + 1));
      load(1'b1, e, (e % 4 == 0) ? 32'd1 : 32'd0);
    end
    run("ident", 1'b0, 1'b0, 1'b0);

    run("same_cycle", 1'b1, 1'b0, 1'b0);

    run("glitch", 1'b0, 1'b1, 1'b0);
    run("replay", 1'b0, 1'b0, 1'b0);

    run("rst_mid", 1'b0, 1'b0, 1'b1);
    run("after_rst", 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < 9; e++) begin
        load(1'b0, e, $urandom);
        load(1'b1, e, $urandom);
      end
      load(1'($urandom), $urandom_range(9, 15), $urandom);
      run($sformatf("rand%0d", r), 1'b0, r[0], 1'b0);
    end

    load(1'b0, 12, 32'h55);
    load(1'b1, 12, 32'h55);
    run("oob", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
